pokey_audio_channel: RTL and testbench
======================================

Name: pokey_audio_channel

Overview:
- One POKEY audio channel.
- Holds the 8-bit AUDC control register and selects between tone, poly4 and poly17/9 noise, with optional poly5 gating.
- Clocked by the channel timer pulse. Applies volume, and optionally a high-pass stage.
- Passes the poly bits down a one-tick delay chain to the next channel. Four instances sit between freq_control/poly_core and the output mixer.

Parameters:
- HP_EN, 0, 1 = high-pass stage present (channels 1/2); 0 = hpClkN/hpDis ignored, stage removed.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high reset
- enn  in  1  1.79 MHz tick enable, one clk wide; all state changes only on clk edges with enn=1
- D  in  8  data bus
- audcWr  in  1  AUDC write strobe, level, sampled on enn
- poly4In, poly5In, poly17In  in  1 each  poly bits from previous stage
- timer  in  1  channel timer underflow pulse, sampled on enn
- rstAudPhase  in  1  audio phase reset (STIMER), sampled on enn
- hpDis  in  1  1 = bypass high-pass
- hpClkN  in  1  active-low high-pass clock strobe (inverted timer of partner channel), sampled on enn
- AUD  out  4  channel volume output
- poly4Out, poly5Out, poly17Out  out  1 each  poly bits delayed one enn tick

Behaviour:
- Reset: audc=0x00, chFF=0, hpFF=0, poly delay regs=0, AUD=0.
- AUDC register: on enn && audcWr, audc <= D.
  - [7] = no-poly5 gate.
  - [6] = poly4 select.
  - [5] = pure tone.
  - [4] = volume only.
  - [3:0] = volume.
- Delay chain: on enn, polyXOut <= polyXIn (X = 4, 5, 17).
- Channel clock: clkEv = enn && timer && (audc[7] || poly5In).
- chFF update on clkEv:
  - audc[5]=1: chFF <= ~chFF.
  - else audc[6]=1: chFF <= poly4In.
  - else: chFF <= poly17In.
- rstAudPhase on enn forces chFF <= 0. It has priority over clkEv in the same tick.
- High-pass (HP_EN=1):
  - On enn && !hpClkN: hpFF <= chFF, using the pre-update value.
  - rstAudPhase clears hpFF.
  - Effective bit e = hpDis ? chFF : (chFF ^ hpFF).
- HP_EN=0: e = chFF.
- Output (combinational from registers): AUD = audc[4] ? audc[3:0] : (e ? audc[3:0] : 4'h0). AUD is valid one clk after the enn edge that changed state.
- Simultaneous events:
  - Write to AUDC in the same tick as clkEv: the chFF update uses the old audc.
  - The new volume shows the following clk.
- audcWr held across multiple enn ticks: reloads each tick, which is harmless.

Decomposition:
- Shared package pokey_pkg:
  - AUDC bit indices: NOPOLY5=7, POLY4SEL=6, PURETONE=5, VOLONLY=4; VOL range 3:0.
  - Width constant for the 4-bit volume.
- One natural sub-module: pokey_hp_stage (hpFF plus XOR/bypass), generated only when HP_EN=1.

Test Plan:
- Reset asserted mid-tone: AUD=0, polyXOut=0, audc=0; after release with no writes, AUD stays 0 under timer pulses (volume 0).
- Pure tone: write D=0xEF, then four timer pulses on enn. AUD sequence is F,0,F,0, each change one clk after the pulse tick. rstAudPhase then gives AUD=0.
- Volume only: write D=0x1A with no timer activity. AUD=0xA immediately after the write tick and constant through timer pulses.
- Poly5 gate: write D=0x6C.
  - poly5In=0 during 3 timer pulses: AUD unchanged (0).
  - poly5In=1: each pulse toggles AUD 0xC/0.
- Noise select with D7=1: write D=0xC5 (poly4) and drive poly4In=1 then 0 on successive timer pulses: AUD=5 then 0. With D=0x85, poly17In drives the output identically.
- Delay chain and high-pass:
  - Drive poly4In/5In/17In = 1,0,1. Outputs match one enn tick later.
  - HP_EN=1, hpDis=0, tone 0xEF: after chFF=1, pulse hpClkN low. AUD=0 until the next timer toggle, then F.
  - hpDis=1 restores plain tone.

Source files
------------

// File: rtl/pokey_pkg.sv
// Shared constants and helpers for the POKEY audio channel slice.
package pokey_pkg;

  // Width of the channel volume field and of the AUD output
  localparam int VOL_W = 4;

  // AUDC control register bit positions
  localparam int AUDC_NOPOLY5  = 7;
  localparam int AUDC_POLY4SEL = 6;
  localparam int AUDC_PURETONE = 5;
  localparam int AUDC_VOLONLY  = 4;
  localparam int AUDC_VOL_HI   = 3;
  localparam int AUDC_VOL_LO   = 0;

  // Volume seen at the output for a given AUDC value and effective channel bit
  function automatic logic [VOL_W-1:0] aud_level(input logic [7:0] audc, input logic e);
    logic [VOL_W-1:0] lvl;
    if (audc[AUDC_VOLONLY] || e) begin
      lvl = audc[AUDC_VOL_HI:AUDC_VOL_LO];
    end else begin
      lvl = {VOL_W{1'b0}};
    end
    return lvl;
  endfunction

endpackage

// File: rtl/pokey_hp_stage.sv
// High-pass stage: samples the channel flip-flop on the partner channel's
// timer strobe and XORs it back into the channel bit unless bypassed.
module pokey_hp_stage
  import pokey_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic enn,
  input  logic hpClkN,
  input  logic rstAudPhase,
  input  logic hpDis,
  input  logic chFF,
  output logic e
);

  logic hp_ff_r;

  // Capture the pre-update channel bit on the active-low HP strobe; phase reset clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hp_ff_r <= 1'b0;
    end else if (enn) begin
      if (rstAudPhase) begin
        hp_ff_r <= 1'b0;
      end else if (!hpClkN) begin
        hp_ff_r <= chFF;
      end else begin
        hp_ff_r <= hp_ff_r;
      end
    end else begin
      hp_ff_r <= hp_ff_r;
    end
  end

  // Effective channel bit: plain when bypassed, high-passed otherwise
  always_comb begin
    e = 1'b0;
    if (hpDis) begin
      e = chFF;
    end else begin
      e = chFF ^ hp_ff_r;
    end
  end

endmodule

// File: rtl/pokey_audio_channel.sv
// One POKEY audio channel: AUDC register, tone/noise selection with optional
// poly5 gating, optional high-pass stage, volume output and poly delay chain.
module pokey_audio_channel
  import pokey_pkg::*;
#(
  parameter bit HP_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enn,
  input  logic [7:0]       D,
  input  logic             audcWr,
  input  logic             poly4In,
  input  logic             poly5In,
  input  logic             poly17In,
  input  logic             timer,
  input  logic             rstAudPhase,
  input  logic             hpDis,
  input  logic             hpClkN,
  output logic [VOL_W-1:0] AUD,
  output logic             poly4Out,
  output logic             poly5Out,
  output logic             poly17Out
);

  logic [7:0] audc_r;
  logic       ch_ff_r;
  logic       clk_ev_s;
  logic       e_s;

  // Channel clock: timer underflow, passed only when poly5 is high or the gate is disabled
  assign clk_ev_s = enn & timer & (audc_r[AUDC_NOPOLY5] | poly5In);

  // AUDC control register load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      audc_r <= 8'h00;
    end else if (enn && audcWr) begin
      audc_r <= D;
    end else begin
      audc_r <= audc_r;
    end
  end

  // Poly bits pass to the next channel one tick late
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      poly4Out  <= 1'b0;
      poly5Out  <= 1'b0;
      poly17Out <= 1'b0;
    end else if (enn) begin
      poly4Out  <= poly4In;
      poly5Out  <= poly5In;
      poly17Out <= poly17In;
    end else begin
      poly4Out  <= poly4Out;
      poly5Out  <= poly5Out;
      poly17Out <= poly17Out;
    end
  end

  // Channel flip-flop; phase reset wins over a same-tick channel clock, and
  // the source selection uses the AUDC value held before any same-tick write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_ff_r <= 1'b0;
    end else if (enn && rstAudPhase) begin
      ch_ff_r <= 1'b0;
    end else if (clk_ev_s) begin
      if (audc_r[AUDC_PURETONE]) begin
        ch_ff_r <= ~ch_ff_r;
      end else if (audc_r[AUDC_POLY4SEL]) begin
        ch_ff_r <= poly4In;
      end else begin
        ch_ff_r <= poly17In;
      end
    end else begin
      ch_ff_r <= ch_ff_r;
    end
  end

  generate
    if (HP_EN) begin : g_hp
      pokey_hp_stage u_hp (
        .clk         (clk),
        .reset       (reset),
        .enn         (enn),
        .hpClkN      (hpClkN),
        .rstAudPhase (rstAudPhase),
        .hpDis       (hpDis),
        .chFF        (ch_ff_r),
        .e           (e_s)
      );
    end else begin : g_no_hp
      logic unused_hp_s;
      assign unused_hp_s = hpDis ^ hpClkN;
      assign e_s         = ch_ff_r;
    end
  endgenerate

  // Output volume decoded straight from registered state
  always_comb begin
    AUD = {VOL_W{1'b0}};
    AUD = aud_level(audc_r, e_s);
  end

endmodule

// File: tb/tb_pokey_audio_channel.sv
// Directed self-checking bench for pokey_audio_channel (high-pass present).
module tb_pokey_audio_channel;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enn = 1'b0;
  logic [7:0] D = 8'h00;
  logic       audcWr = 1'b0;
  logic       poly4In = 1'b0;
  logic       poly5In = 1'b0;
  logic       poly17In = 1'b0;
  logic       timer = 1'b0;
  logic       rstAudPhase = 1'b0;
  logic       hpDis = 1'b1;
  logic       hpClkN = 1'b1;
  logic [3:0] AUD;
  logic       poly4Out;
  logic       poly5Out;
  logic       poly17Out;

  int total = 0;
  int bad = 0;

  pokey_audio_channel #(.HP_EN(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .enn         (enn),
    .D           (D),
    .audcWr      (audcWr),
    .poly4In     (poly4In),
    .poly5In     (poly5In),
    .poly17In    (poly17In),
    .timer       (timer),
    .rstAudPhase (rstAudPhase),
    .hpDis       (hpDis),
    .hpClkN      (hpClkN),
    .AUD         (AUD),
    .poly4Out    (poly4Out),
    .poly5Out    (poly5Out),
    .poly17Out   (poly17Out)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One enn tick with whatever strobes the caller set; strobes are cleared afterwards
  // and the task returns on a falling edge after the state update.
  task automatic tick();
    @(negedge clk);
    enn = 1'b1;
    @(negedge clk);
    enn = 1'b0;
    audcWr = 1'b0;
    timer = 1'b0;
    rstAudPhase = 1'b0;
    hpClkN = 1'b1;
  endtask

  task automatic wr(input logic [7:0] v);
    D = v;
    audcWr = 1'b1;
    tick();
  endtask

  task automatic pulse();
    timer = 1'b1;
    tick();
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_aud", {4'h0, AUD}, 8'h00);
    chk("reset_poly", {5'b0, poly4Out, poly5Out, poly17Out}, 8'h00);
    reset = 1'b0;

    // Reset asserted mid-tone
    poly4In = 1'b1; poly5In = 1'b1; poly17In = 1'b1;
    wr(8'hEF);
    pulse();
    chk("pre_rst_tone", {4'h0, AUD}, 8'h0F);
    chk("pre_rst_poly", {5'b0, poly4Out, poly5Out, poly17Out}, 8'h07);
    #3 reset = 1'b1;
    #1;
    chk("async_rst_aud", {4'h0, AUD}, 8'h00);
    chk("async_rst_poly", {5'b0, poly4Out, poly5Out, poly17Out}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    poly4In = 1'b0; poly17In = 1'b0;
    pulse();
    pulse();
    chk("post_rst_vol0", {4'h0, AUD}, 8'h00);

    // Pure tone F,0,F,0
    wr(8'hEF);
    chk("tone_write", {4'h0, AUD}, 8'h00);
    pulse(); chk("tone_p1", {4'h0, AUD}, 8'h0F);
    pulse(); chk("tone_p2", {4'h0, AUD}, 8'h00);
    pulse(); chk("tone_p3", {4'h0, AUD}, 8'h0F);
    pulse(); chk("tone_p4", {4'h0, AUD}, 8'h00);
    // no state change on a timer pulse without enn
    timer = 1'b1;
    repeat (2) @(negedge clk);
    timer = 1'b0;
    chk("tone_no_enn", {4'h0, AUD}, 8'h00);
    pulse(); chk("tone_p5", {4'h0, AUD}, 8'h0F);
    rstAudPhase = 1'b1;
    tick();
    chk("tone_phase_rst", {4'h0, AUD}, 8'h00);
    pulse(); chk("tone_p6", {4'h0, AUD}, 8'h0F);
    rstAudPhase = 1'b1; timer = 1'b1;
    tick();
    chk("phase_rst_prio", {4'h0, AUD}, 8'h00);

    // Volume only
    wr(8'h1A);
    chk("volonly_write", {4'h0, AUD}, 8'h0A);
    pulse(); chk("volonly_p1", {4'h0, AUD}, 8'h0A);
    pulse(); chk("volonly_p2", {4'h0, AUD}, 8'h0A);

    // Poly5 gate
    poly5In = 1'b0;
    D = 8'h6C; audcWr = 1'b1; rstAudPhase = 1'b1;
    tick();
    chk("gate_write", {4'h0, AUD}, 8'h00);
    pulse(); pulse(); pulse();
    chk("gate_closed", {4'h0, AUD}, 8'h00);
    poly5In = 1'b1;
    pulse(); chk("gate_open_p1", {4'h0, AUD}, 8'h0C);
    pulse(); chk("gate_open_p2", {4'h0, AUD}, 8'h00);
    pulse(); chk("gate_open_p3", {4'h0, AUD}, 8'h0C);

    // Noise select, poly5 gate off
    poly5In = 1'b0;
    D = 8'hC5; audcWr = 1'b1; rstAudPhase = 1'b1;
    tick();
    poly4In = 1'b1; pulse(); chk("poly4_hi", {4'h0, AUD}, 8'h05);
    poly4In = 1'b0; pulse(); chk("poly4_lo", {4'h0, AUD}, 8'h00);
    wr(8'h85);
    poly17In = 1'b1; pulse(); chk("poly17_hi", {4'h0, AUD}, 8'h05);
    poly17In = 1'b0; poly4In = 1'b1;
    pulse(); chk("poly17_lo", {4'h0, AUD}, 8'h00);

    // Write and channel clock in the same tick: old AUDC selects poly17 (=0)
    poly4In = 1'b0;
    D = 8'hAF; audcWr = 1'b1; timer = 1'b1;
    tick();
    chk("same_tick_old_audc", {4'h0, AUD}, 8'h00);
    pulse(); chk("same_tick_next", {4'h0, AUD}, 8'h0F);

    // Delay chain
    poly4In = 1'b1; poly5In = 1'b0; poly17In = 1'b1;
    tick();
    chk("delay_101", {5'b0, poly4Out, poly5Out, poly17Out}, 8'h05);
    poly4In = 1'b0; poly5In = 1'b1; poly17In = 1'b0;
    repeat (2) @(negedge clk);
    chk("delay_hold", {5'b0, poly4Out, poly5Out, poly17Out}, 8'h05);
    tick();
    chk("delay_010", {5'b0, poly4Out, poly5Out, poly17Out}, 8'h02);

    // High-pass
    hpDis = 1'b0;
    D = 8'hEF; audcWr = 1'b1; rstAudPhase = 1'b1;
    tick();
    chk("hp_start", {4'h0, AUD}, 8'h00);
    pulse(); chk("hp_ch1", {4'h0, AUD}, 8'h0F);
    hpClkN = 1'b0;
    tick();
    chk("hp_clk", {4'h0, AUD}, 8'h00);
    pulse(); chk("hp_toggle", {4'h0, AUD}, 8'h0F);
    pulse(); chk("hp_toggle2", {4'h0, AUD}, 8'h00);
    hpDis = 1'b1;
    #1;
    chk("hp_bypass", {4'h0, AUD}, 8'h0F);
    hpDis = 1'b0;
    rstAudPhase = 1'b1;
    tick();
    chk("hp_phase_rst", {4'h0, AUD}, 8'h00);
    pulse();
    chk("hp_ch1_again", {4'h0, AUD}, 8'h0F);
    // HP capture and channel toggle in the same tick: HP takes the old chFF (1)
    hpClkN = 1'b0; timer = 1'b1;
    tick();
    chk("hp_pre_update", {4'h0, AUD}, 8'h0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
